// File: rtl/serial_frame_capture.sv
// serial_frame_capture
// Serial-to-parallel capture for single-bit debug/telemetry streams. Hunts for
// SYNC_PAT, then frames FRAME_WORDS words of WIDTH bits (MSB first) followed by
// a SYNC_W-bit sync field. Lock drops after MISS_MAX consecutive sync misses.
//
// Optional build macro: SERIAL_FRAME_CAPTURE_STATS_EN
//   defined   -> frame_cnt_o / miss_cnt_o are saturating statistics counters
//   undefined -> counter logic is not built, both outputs tie to 0
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_HUNT | searching the stream for SYNC_PAT, locked_o low
// ST_DATA | assembling data words of the current frame
// ST_SYNC | collecting the sync field that trails every frame
module serial_frame_capture #(
    parameter int                WIDTH       = 32,
    parameter int                SYNC_W      = 8,
    parameter logic [SYNC_W-1:0] SYNC_PAT    = 8'hA5,
    parameter int                FRAME_WORDS = 4,
    parameter int                MISS_MAX    = 3,
    parameter int                CNT_W       = 16,
    localparam int               IW          = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_i,
    input  logic             data_val_i,
    output logic [WIDTH-1:0] word_o,
    output logic             word_val_o,
    output logic [IW-1:0]    word_idx_o,
    output logic             sof_o,
    output logic             locked_o,
    output logic             sync_miss_o,
    output logic [CNT_W-1:0] frame_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o
);

    // The bit counter times both word and sync fields, so it is sized for the longer one.
    localparam int MAXLEN = (WIDTH > SYNC_W) ? WIDTH : SYNC_W;
    localparam int BW     = $clog2(MAXLEN);
    localparam int MW     = $clog2(MISS_MAX + 1);

    localparam logic [BW-1:0] WORD_LOAD = BW'(WIDTH - 1);
    localparam logic [BW-1:0] SYNC_LOAD = BW'(SYNC_W - 1);
    localparam logic [IW-1:0] LAST_WORD = IW'(FRAME_WORDS - 1);
    localparam logic [MW-1:0] LAST_MISS = MW'(MISS_MAX - 1);

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_DATA = 2'd1,
        ST_SYNC = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-2:0] word_sr_q, word_sr_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [IW-1:0]    word_cnt_q, word_cnt_d;
    logic [MW-1:0]    consec_q, consec_d;

    logic [WIDTH-1:0] word_q, word_d;
    logic             word_val_q, word_val_d;
    logic [IW-1:0]    word_idx_q, word_idx_d;
    logic             sof_q, sof_d;
    logic             locked_q, locked_d;
    logic             sync_miss_q, sync_miss_d;

    // Last SYNC_W bits of the stream including the bit presented this cycle.
    // Only SYNC_W-1 bits need storage; the live bit completes the field, which
    // serves both the HUNT search and the trailing sync-field compare.
    logic [SYNC_W-1:0] field_w;
    logic [WIDTH-1:0]  word_full;

    generate
        if (SYNC_W == 1) begin : g_hunt_one
            assign field_w = data_i;
        end else begin : g_hunt_reg
            logic [SYNC_W-2:0] hunt_q;

            // Hunt history shifts on every valid bit in every state and is never
            // cleared on lock loss, so a failed field cannot trigger a false relock.
            always_ff @(posedge clk) begin
                if (rst) begin
                    hunt_q <= '0;
                end else if (data_val_i) begin
                    hunt_q <= field_w[SYNC_W-2:0];
                end
            end

            assign field_w = {hunt_q, data_i};
        end
    endgenerate

    assign word_full = {word_sr_q, data_i};

    // Framing state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            word_sr_q   <= '0;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            consec_q    <= '0;
            word_q      <= '0;
            word_val_q  <= 1'b0;
            word_idx_q  <= '0;
            sof_q       <= 1'b0;
            locked_q    <= 1'b0;
            sync_miss_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_sr_q   <= word_sr_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            consec_q    <= consec_d;
            word_q      <= word_d;
            word_val_q  <= word_val_d;
            word_idx_q  <= word_idx_d;
            sof_q       <= sof_d;
            locked_q    <= locked_d;
            sync_miss_q <= sync_miss_d;
        end
    end

    // Next-state and output decode; nothing moves on cycles without a valid bit.
    always_comb begin
        state_d     = state_q;
        word_sr_d   = word_sr_q;
        bit_cnt_d   = bit_cnt_q;
        word_cnt_d  = word_cnt_q;
        consec_d    = consec_q;
        word_d      = word_q;
        word_idx_d  = word_idx_q;
        word_val_d  = 1'b0;
        sof_d       = 1'b0;
        sync_miss_d = 1'b0;

        if (data_val_i) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (field_w == SYNC_PAT) begin
                        state_d    = ST_DATA;
                        bit_cnt_d  = WORD_LOAD;
                        word_cnt_d = '0;
                        consec_d   = '0;
                    end
                end

                ST_DATA: begin
                    word_sr_d = word_full[WIDTH-2:0];
                    if (bit_cnt_q == '0) begin
                        word_d     = word_full;
                        word_val_d = 1'b1;
                        word_idx_d = word_cnt_q;
                        sof_d      = (word_cnt_q == '0);
                        if (word_cnt_q == LAST_WORD) begin
                            state_d    = ST_SYNC;
                            word_cnt_d = '0;
                            bit_cnt_d  = SYNC_LOAD;
                        end else begin
                            word_cnt_d = word_cnt_q + IW'(1);
                            bit_cnt_d  = WORD_LOAD;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q - BW'(1);
                    end
                end

                ST_SYNC: begin
                    if (bit_cnt_q == '0) begin
                        bit_cnt_d = WORD_LOAD;
                        if (field_w == SYNC_PAT) begin
                            consec_d = '0;
                            state_d  = ST_DATA;
                        end else begin
                            sync_miss_d = 1'b1;
                            if (consec_q == LAST_MISS) begin
                                consec_d = '0;
                                state_d  = ST_HUNT;
                            end else begin
                                // Flywheel: keep frame alignment through isolated misses.
                                consec_d = consec_q + MW'(1);
                                state_d  = ST_DATA;
                            end
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q - BW'(1);
                    end
                end

                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end
    end

    assign locked_d = (state_d != ST_HUNT);

`ifdef SERIAL_FRAME_CAPTURE_STATS_EN
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic             frame_done;

    assign frame_done = (state_q == ST_DATA) && (state_d == ST_SYNC);

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        if (frame_done && (frame_cnt_q != '1)) begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end
        if (sync_miss_d && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
            miss_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign frame_cnt_o = frame_cnt_q;
    assign miss_cnt_o  = miss_cnt_q;
`else
    assign frame_cnt_o = '0;
    assign miss_cnt_o  = '0;
`endif

    assign word_o      = word_q;
    assign word_val_o  = word_val_q;
    assign word_idx_o  = word_idx_q;
    assign sof_o       = sof_q;
    assign locked_o    = locked_q;
    assign sync_miss_o = sync_miss_q;

endmodule

// File: tb/tb_serial_frame_capture.sv
// Scoreboard bench for serial_frame_capture (default parameters).
// Stimulus pushes expected words; a negedge monitor pops and compares them.
// Statistics expectations follow SERIAL_FRAME_CAPTURE_STATS_EN (0 when undefined).
module tb_serial_frame_capture;

`ifdef SERIAL_FRAME_CAPTURE_STATS_EN
    localparam logic [15:0] STAT_MASK = 16'hFFFF;
`else
    localparam logic [15:0] STAT_MASK = 16'h0000;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        data_i;
    logic        data_val_i;
    logic [31:0] word_o;
    logic        word_val_o;
    logic [1:0]  word_idx_o;
    logic        sof_o;
    logic        locked_o;
    logic        sync_miss_o;
    logic [15:0] frame_cnt_o;
    logic [15:0] miss_cnt_o;

    typedef struct packed {
        logic [31:0] word;
        logic [1:0]  idx;
        logic        sof;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          gap = 0;
    int          exp_frames = 0;
    int          exp_misses = 0;
    int          exp_pulses = 0;
    int          miss_pulses = 0;
    logic [31:0] last_word = '0;
    bit          mon_en = 1'b0;

    serial_frame_capture dut (
        .clk         (clk),
        .rst         (rst),
        .data_i      (data_i),
        .data_val_i  (data_val_i),
        .word_o      (word_o),
        .word_val_o  (word_val_o),
        .word_idx_o  (word_idx_o),
        .sof_o       (sof_o),
        .locked_o    (locked_o),
        .sync_miss_o (sync_miss_o),
        .frame_cnt_o (frame_cnt_o),
        .miss_cnt_o  (miss_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] stat(input int v);
        return 16'(v) & STAT_MASK;
    endfunction

    task automatic send_bit(input logic b);
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            data_val_i = 1'b0;
            data_i     = ~b;
        end
        @(negedge clk);
        data_val_i = 1'b1;
        data_i     = b;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_word(input logic [31:0] w, input int idx);
        exp_q.push_back('{word: w, idx: 2'(idx), sof: (idx == 0)});
        send_bits(w, 32);
    endtask

    task automatic send_frame(input logic [127:0] f);
        for (int i = 0; i < 4; i++) send_word(f[127-32*i -: 32], i);
        exp_frames++;
    endtask

    task automatic send_sync(input logic [7:0] s);
        send_bits({24'h0, s}, 8);
        if (s != 8'hA5) begin
            exp_misses++;
            exp_pulses++;
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            data_val_i = 1'b0;
            data_i     = 1'b0;
        end
    endtask

    task automatic apply_reset(input logic with_data);
        @(negedge clk);
        rst        = 1'b1;
        data_val_i = with_data;
        data_i     = 1'b1;
        after_edge();
        last_word  = '0;
        mon_en     = 1'b1;
        exp_frames = 0;
        exp_misses = 0;
        check("rst_word", 64'(word_o), 64'h0);
        check("rst_val", 64'(word_val_o), 64'h0);
        check("rst_idx", 64'(word_idx_o), 64'h0);
        check("rst_sof", 64'(sof_o), 64'h0);
        check("rst_locked", 64'(locked_o), 64'h0);
        check("rst_miss", 64'(sync_miss_o), 64'h0);
        check("rst_frame_cnt", 64'(frame_cnt_o), 64'h0);
        check("rst_miss_cnt", 64'(miss_cnt_o), 64'h0);
        @(negedge clk);
        rst        = 1'b0;
        data_val_i = 1'b0;
        data_i     = 1'b0;
    endtask

    task automatic lock(input string tag);
        send_bits(32'hA5, 8);
        check({tag, "_prelock"}, 64'(locked_o), 64'h0);
        after_edge();
        check({tag, "_lock"}, 64'(locked_o), 64'h1);
    endtask

    task automatic end_scenario(input string tag);
        idle(4);
        after_edge();
        check({tag, "_drain"}, 64'(exp_q.size()), 64'h0);
        check({tag, "_frame_cnt"}, 64'(frame_cnt_o), 64'(stat(exp_frames)));
        check({tag, "_miss_cnt"}, 64'(miss_cnt_o), 64'(stat(exp_misses)));
        check({tag, "_miss_pulses"}, 64'(miss_pulses), 64'(exp_pulses));
    endtask

    // Monitor: pop and compare each presented word; word_o must hold between strobes.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && !rst) begin
            if (word_val_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got %h idx %0d expected no strobe", word_o, word_idx_o);
                end else begin
                    e = exp_q.pop_front();
                    check("word", 64'(word_o), 64'(e.word));
                    check("word_idx", 64'(word_idx_o), 64'(e.idx));
                    check("sof", 64'(sof_o), 64'(e.sof));
                    last_word = e.word;
                end
            end else begin
                check("word_hold", 64'(word_o), 64'(last_word));
                check("sof_idle", 64'(sof_o), 64'h0);
            end
            if (sync_miss_o) miss_pulses++;
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    localparam logic [127:0] F1 = {32'h12345678, 32'h9ABCDEF0, 32'hDEADBEEF, 32'h00000001};
    localparam logic [127:0] F2 = {32'hCAFEF00D, 32'h0F0F0F0F, 32'h80000000, 32'hFFFFFFFE};
    localparam logic [127:0] F3 = {32'h00000000, 32'hA5A5A5A5, 32'h13579BDF, 32'h2468ACE0};

    initial begin
        rst        = 1'b0;
        data_i     = 1'b0;
        data_val_i = 1'b0;

        // Basic lock and one frame.
        apply_reset(1'b0);
        lock("s1");
        send_frame(F1);
        send_sync(8'hA5);
        after_edge();
        check("s1_locked_after_sync", 64'(locked_o), 64'h1);
        end_scenario("s1");

        // Same stream, valid one cycle in three.
        apply_reset(1'b0);
        gap = 2;
        lock("s2");
        send_frame(F1);
        send_sync(8'hA5);
        end_scenario("s2");
        gap = 0;

        // Single sync miss, flywheel keeps alignment.
        apply_reset(1'b0);
        lock("s3");
        send_frame(F1);
        send_sync(8'h5A);
        after_edge();
        check("s3_miss_pulse", 64'(sync_miss_o), 64'h1);
        check("s3_still_locked", 64'(locked_o), 64'h1);
        send_frame(F2);
        send_sync(8'hA5);
        end_scenario("s3");

        // Three consecutive misses drop lock; relock on fresh pattern.
        apply_reset(1'b0);
        lock("s4");
        for (int k = 0; k < 3; k++) begin
            send_frame((k == 1) ? F2 : F3);
            send_sync(8'h00);
            after_edge();
            check("s4_miss_pulse", 64'(sync_miss_o), 64'h1);
            check("s4_locked", 64'(locked_o), (k == 2) ? 64'h0 : 64'h1);
        end
        send_bits(32'h0, 32);
        send_bits(32'h0, 32);
        after_edge();
        check("s4_hunting", 64'(locked_o), 64'h0);
        lock("s4_re");
        send_frame(F1);
        send_sync(8'hA5);
        end_scenario("s4");

        // Reset mid-frame after 10 data bits, rst wins over valid data.
        apply_reset(1'b0);
        lock("s5");
        send_bits(32'h12345678 >> 22, 10);
        apply_reset(1'b1);
        lock("s5_re");
        send_frame(F2);
        send_sync(8'hA5);
        end_scenario("s5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
